// File: rtl/tdm_demux_if.sv
// tdm_demux_if: upstream TDM handshake, downstream extracted-word handshake and slot index
interface tdm_demux_if #(
  parameter int DWIDTH     = 16,
  parameter int NR_STREAMS = 16
);
  localparam int SW = $clog2(NR_STREAMS);
  logic              req_in;
  logic              ack_in;
  logic [DWIDTH-1:0] data_in;
  logic              req_out;
  logic              ack_out;
  logic [DWIDTH-1:0] data_out;
  logic [SW-1:0]     slot_cnt;
  modport slave (
    output req_in, req_out, data_out, slot_cnt,
    input  ack_in, data_in, ack_out
  );
  modport master (
    input  req_in, req_out, data_out, slot_cnt,
    output ack_in, data_in, ack_out
  );
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: extracts one slot of a TDM frame into a small output FIFO
module tdm_demux #(
  parameter int DWIDTH      = 16,
  parameter int NR_STREAMS  = 16,
  parameter int STREAMS_IDX = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input logic         clk,
  input logic         rst,
  tdm_demux_if.slave  bus
);
  localparam int SW = $clog2(NR_STREAMS);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [SW-1:0]     r_slot;
  logic [AW-1:0]     r_wr, r_rd;
  logic [AW:0]       r_cnt;
  logic [DWIDTH-1:0] r_mem [FIFO_DEPTH];
  logic w_full, w_tgt, w_req_in, w_req_out, w_in, w_push, w_pop;
  always_comb begin
    w_full    = r_cnt == (AW+1)'(FIFO_DEPTH);
    w_tgt     = r_slot == SW'(STREAMS_IDX);
    // only the target slot stalls on a full FIFO; other slots keep draining upstream
    w_req_in  = !rst && !(w_full && w_tgt);
    w_req_out = !rst && r_cnt != '0;
    w_in      = w_req_in && bus.ack_in;
    w_push    = w_in && w_tgt;
    w_pop     = w_req_out && bus.ack_out;
  end
  assign bus.req_in   = w_req_in;
  assign bus.req_out  = w_req_out;
  assign bus.data_out = w_req_out ? r_mem[r_rd] : '0;
  assign bus.slot_cnt = rst ? '0 : r_slot;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_in) r_slot <= r_slot == SW'(NR_STREAMS-1) ? '0 : r_slot + 1'b1;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= bus.data_in;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed scenarios plus random traffic against a queue-based reference model
module tb_tdm_demux;
  localparam int DW = 16, NR = 4, IDX = 2, DEPTH = 2;
  logic clk = 0;
  logic rst = 1;
  int n_checks = 0, n_fail = 0;
  int slot = 0, tag_n = 0;
  logic [DW-1:0] q[$];
  tdm_demux_if #(.DWIDTH(DW), .NR_STREAMS(NR)) bus ();
  tdm_demux #(.DWIDTH(DW), .NR_STREAMS(NR), .STREAMS_IDX(IDX), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] dat();
    return slot == IDX ? DW'(16'hA1 + tag_n) : DW'(16'h50 + slot);
  endfunction
  task automatic step(input logic r, input logic ai, input logic [DW-1:0] d, input logic ao);
    logic e_ri, e_ro;
    rst = r;
    bus.ack_in = ai;
    bus.data_in = d;
    bus.ack_out = ao;
    @(negedge clk);
    e_ri = !r && !(q.size() == DEPTH && slot == IDX);
    e_ro = !r && q.size() != 0;
    check("req_in", 32'(bus.req_in), 32'(e_ri));
    check("req_out", 32'(bus.req_out), 32'(e_ro));
    check("slot_cnt", 32'(bus.slot_cnt), r ? 0 : slot);
    if (e_ro || r) check("data_out", 32'(bus.data_out), e_ro ? 32'(q[0]) : 0);
    @(posedge clk);
    if (r) begin
      q.delete();
      slot = 0;
    end else begin
      if (e_ro && ao) void'(q.pop_front());
      if (e_ri && ai) begin
        if (slot == IDX) begin
          q.push_back(d);
          tag_n++;
        end
        slot = (slot + 1) % NR;
      end
    end
    #1;
  endtask
  initial begin
    bus.ack_in = 0;
    bus.data_in = 0;
    bus.ack_out = 0;
    step(1, 1, 16'hFFFF, 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, DW'(16'h10 + i), 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    tag_n = 0;
    for (int i = 0; i < 12; i++) step(0, 1, dat(), 0);
    step(0, 1, dat(), 1);
    step(0, 1, dat(), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, dat(), 0);
    step(0, 1, 16'hB2, 1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 16'hC0 + DW'(i), 0);
    step(1, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 16'hD0 + DW'(i), 0);
    for (int i = 0; i < 12; i++) step(0, 1, dat(), 0);
    for (int i = 0; i < 10; i++) step(0, 1'($urandom), DW'($urandom), 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
